// File: rtl/frv_wide_writeback.sv
// ---------------------------------------------------------------------------
// frv_wide_writeback
//
// Writeback sequencer that sits directly behind the bitwise/rotate unit and
// drives the single GPR write port. A narrow (32-bit) result commits in one
// write. A wide (64-bit) result commits as an even/odd register pair over two
// consecutive cycles. While the high half is still to be written, the
// producer is held off through s_ready.
//
// Parameters:
//   ZERO_SUPPRESS  1 = never assert rf_wen for a write to x0
//
// Ports:
//   g_clk      in   core clock, rising-edge
//   g_resetn   in   asynchronous active-low reset
//   flush      in   discard accepted-but-uncommitted work
//   s_valid    in   producer result valid
//   s_ready    out  block can accept a result this cycle
//   s_wide     in   1 = 64-bit result (two writes), 0 = 32-bit result
//   s_rd       in   destination register
//   s_result   in   result data (narrow uses [31:0])
//   rf_wen     out  GPR write enable
//   rf_addr    out  GPR write address
//   rf_wdata   out  GPR write data
//   hz_busy    out  a write is committing now or next cycle
//   hz_addr    out  odd register of the pending high-half write (WHI only)
// ---------------------------------------------------------------------------
module frv_wide_writeback #(
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_wide,
    input  logic [4:0]  s_rd,
    input  logic [63:0] s_result,
    output logic        rf_wen,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        hz_busy,
    output logic [4:0]  hz_addr
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WLO   = 2'd1;
    localparam logic [1:0] ST_WHI   = 2'd2;

    logic [1:0]  state;
    logic        held_wide;
    logic [3:0]  held_pair;
    logic [31:0] held_hi;

    logic        accept;
    logic [4:0]  acc_addr;
    logic        acc_wen;

    // Only a held wide op in its low-write cycle blocks the producer: its
    // high half needs the write port next cycle.
    always_comb begin
        s_ready = 1'b1;
        if ((state == ST_WLO) && held_wide) begin
            s_ready = 1'b0;
        end
    end

    // First write of an incoming op. Wide ops land on the even register of
    // the pair, so bit 0 of rd is dropped for them.
    always_comb begin
        accept   = s_valid && s_ready && !flush;
        acc_addr = s_wide ? {s_rd[4:1], 1'b0} : s_rd;
        acc_wen  = !(ZERO_SUPPRESS && (acc_addr == 5'd0));
    end

    // Sequencer. Flush wins over everything: whatever is on the write port
    // this cycle still commits, but nothing further is issued, so a wide
    // op's high half is cancelled if flush arrives during its low write.
    // rf_addr/rf_wdata only change when a new write is issued, so they hold
    // their last value while rf_wen is low.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state     <= ST_EMPTY;
            held_wide <= 1'b0;
            held_pair <= 4'd0;
            held_hi   <= 32'd0;
            rf_wen    <= 1'b0;
            rf_addr   <= 5'd0;
            rf_wdata  <= 32'd0;
        end else if (flush) begin
            state  <= ST_EMPTY;
            rf_wen <= 1'b0;
        end else if ((state == ST_WLO) && held_wide) begin
            state    <= ST_WHI;
            rf_wen   <= 1'b1;
            rf_addr  <= {held_pair, 1'b1};
            rf_wdata <= held_hi;
        end else if (accept) begin
            state     <= ST_WLO;
            held_wide <= s_wide;
            held_pair <= s_rd[4:1];
            held_hi   <= s_result[63:32];
            rf_wen    <= acc_wen;
            rf_addr   <= acc_addr;
            rf_wdata  <= s_result[31:0];
        end else begin
            state  <= ST_EMPTY;
            rf_wen <= 1'b0;
        end
    end

    // Hazard view for the issue stage.
    always_comb begin
        hz_busy = (state != ST_EMPTY);
        hz_addr = 5'd0;
        if (state == ST_WHI) begin
            hz_addr = {held_pair, 1'b1};
        end
    end

endmodule
